bomb_put_arbiter: RTL and testbench

Sits between the player input and movement logic and the bomb tile datapath. It converts raw per-player bomb-button levels into the single-cycle p1_put/p2_put pulses the datapath consumes. It enforces per-player live-bomb capacity, refuses occupied or exploding tiles, and arbitrates same-tile, same-cycle requests with a fairness bit. It also owns the live-bomb count per player, using one countdown slot per live bomb.

---
 rtl/bomb_pkg.sv | 42 ++++
 rtl/bomb_slot_bank.sv | 61 ++++++
 rtl/bomb_put_arbiter.sv | 147 ++++++++++++++
 tb/tb_bomb_put_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bomb_pkg.sv
// Shared definitions for the bomb game: tile states, player ids, game status,
// the bomb-put FSM encoding and the capacity clamp helper.
package bomb_pkg;

    localparam logic [2:0] EMPTY     = 3'd0;
    localparam logic [2:0] READY_EXP = 3'd1;
    localparam logic [2:0] BOMB_UN   = 3'd2;
    localparam logic [2:0] EXP_UP    = 3'd3;
    localparam logic [2:0] EXP_DOWN  = 3'd4;
    localparam logic [2:0] EXP_LEFT  = 3'd5;
    localparam logic [2:0] EXP_RIGHT = 3'd6;
    localparam logic [2:0] EXP_CEN   = 3'd7;

    localparam logic P1 = 1'b0;
    localparam logic P2 = 1'b1;

    localparam logic [1:0] NOT_OVER  = 2'd0;
    localparam logic [1:0] GAME_OVER = 2'd1;
    localparam logic [1:0] P1_WIN    = 2'd2;
    localparam logic [1:0] P2_WIN    = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        HELD = 2'd2
    } put_fsm_t;

    // A capacity of 0 still allows one bomb; anything above the slot count
    // is limited to the number of physical slots.
    function automatic logic [2:0] eff_cap(input logic [2:0] cap, input int max_slots);
        logic [2:0] capped;
        if (cap == 3'd0) begin
            capped = 3'd1;
        end else if (int'(cap) > max_slots) begin
            capped = 3'(max_slots);
        end else begin
            capped = cap;
        end
        return capped;
    endfunction

endpackage

// File: rtl/bomb_slot_bank.sv
// Per-player bank of live-bomb countdown slots. Each grant occupies the
// lowest free slot for SLOT_LIFE cycles; the busy count is registered.
module bomb_slot_bank
    import bomb_pkg::*;
#(
    parameter int MAX_SLOTS = 4,
    parameter int SLOT_LIFE = 61
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 alloc,
    output logic [MAX_SLOTS-1:0] busy,
    output logic [2:0]           count
);

    localparam int TW = $clog2(SLOT_LIFE + 1);
    localparam logic [TW-1:0] LIFE = TW'(SLOT_LIFE);
    localparam logic [TW-1:0] ONE  = TW'(1);

    logic [TW-1:0] timer   [MAX_SLOTS];
    logic [TW-1:0] timer_n [MAX_SLOTS];
    logic [2:0]    count_n;
    logic          placed;

    // Decrement busy slots, load the lowest free slot on alloc, and count what stays busy.
    always_comb begin
        placed  = 1'b0;
        count_n = 3'd0;
        for (int i = 0; i < MAX_SLOTS; i++) begin
            timer_n[i] = (timer[i] != '0) ? (timer[i] - ONE) : '0;
            if (alloc && !placed && (timer[i] == '0)) begin
                timer_n[i] = LIFE;
                placed     = 1'b1;
            end
            if (timer_n[i] != '0) begin
                count_n = count_n + 3'd1;
            end
        end
    end

    // Expose which slots currently hold a live bomb.
    always_comb begin
        for (int i = 0; i < MAX_SLOTS; i++) begin
            busy[i] = (timer[i] != '0);
        end
    end

    // Slot timers and the registered busy count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MAX_SLOTS; i++) begin
                timer[i] <= '0;
            end
            count <= 3'd0;
        end else begin
            timer <= timer_n;
            count <= count_n;
        end
    end

endmodule

// File: rtl/bomb_put_arbiter.sv
// Turns bomb-button levels into single-cycle put/deny pulses, enforcing
// per-player capacity, tile availability and fair same-tile arbitration.
module bomb_put_arbiter
    import bomb_pkg::*;
#(
    parameter int MAX_SLOTS = 4,
    parameter int SLOT_LIFE = 61
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         enable,
    input  logic         p1_req,
    input  logic         p2_req,
    input  logic [7:0]   p1_cor,
    input  logic [7:0]   p2_cor,
    input  logic [2:0]   p1_bomb_cap,
    input  logic [2:0]   p2_bomb_cap,
    input  logic [255:0] bomb_un_grid,
    input  logic [255:0] explode,
    output logic         p1_put,
    output logic         p2_put,
    output logic         p1_deny,
    output logic         p2_deny,
    output logic [2:0]   bomb_num_p1,
    output logic [2:0]   bomb_num_p2,
    output logic         prio
);

    logic [1:0]                 req;
    logic [1:0][7:0]            cor;
    logic [1:0][2:0]            cap;
    logic [1:0][2:0]            count;
    logic [1:0][MAX_SLOTS-1:0]  busy;

    put_fsm_t   state   [2];
    put_fsm_t   state_n [2];
    logic [1:0] hist;
    logic [1:0] elig;
    logic [1:0] put_n;
    logic [1:0] put_q;
    logic [1:0] deny_n;
    logic [1:0] deny_q;
    logic       prio_q;
    logic       prio_n;
    logic       conflict;

    assign req = {p2_req, p1_req};
    assign cor = {p2_cor, p1_cor};
    assign cap = {p2_bomb_cap, p1_bomb_cap};

    // A pending request is eligible when the game runs, a slot is free under the cap and the tile is clear.
    always_comb begin
        elig = 2'b00;
        for (int p = 0; p < 2; p++) begin
            elig[p] = (state[p] == PEND) && enable
                      && (count[p] < eff_cap(cap[p], MAX_SLOTS))
                      && !(&busy[p])
                      && !bomb_un_grid[cor[p]] && !explode[cor[p]];
        end
        conflict = (&elig) && (cor[0] == cor[1]);
    end

    // Per-player FSM next state, put/deny decisions and the fairness bit.
    always_comb begin
        prio_n = prio_q;
        put_n  = 2'b00;
        deny_n = 2'b00;
        for (int p = 0; p < 2; p++) begin
            state_n[p] = state[p];
            unique case (state[p])
                IDLE: begin
                    if (req[p] && !hist[p]) begin
                        state_n[p] = PEND;
                    end
                end
                PEND: begin
                    state_n[p] = HELD;
                    if (conflict) begin
                        put_n[p]  = (prio_q == p[0]);
                        deny_n[p] = (prio_q != p[0]);
                    end else begin
                        put_n[p]  = elig[p];
                        deny_n[p] = !elig[p];
                    end
                end
                HELD: begin
                    if (!req[p]) begin
                        state_n[p] = IDLE;
                    end
                end
                default: state_n[p] = IDLE;
            endcase
        end
        if (conflict) begin
            prio_n = !prio_q;
        end
    end

    // State, request history, registered pulses and fairness bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state[0] <= IDLE;
            state[1] <= IDLE;
            hist     <= 2'b00;
            put_q    <= 2'b00;
            deny_q   <= 2'b00;
            prio_q   <= 1'b0;
        end else begin
            state  <= state_n;
            hist   <= req;
            put_q  <= put_n;
            deny_q <= deny_n;
            prio_q <= prio_n;
        end
    end

    bomb_slot_bank #(
        .MAX_SLOTS (MAX_SLOTS),
        .SLOT_LIFE (SLOT_LIFE)
    ) u_slots_p1 (
        .clk     (clk),
        .reset_n (reset_n),
        .alloc   (put_n[0]),
        .busy    (busy[0]),
        .count   (count[0])
    );

    bomb_slot_bank #(
        .MAX_SLOTS (MAX_SLOTS),
        .SLOT_LIFE (SLOT_LIFE)
    ) u_slots_p2 (
        .clk     (clk),
        .reset_n (reset_n),
        .alloc   (put_n[1]),
        .busy    (busy[1]),
        .count   (count[1])
    );

    assign p1_put      = put_q[0];
    assign p2_put      = put_q[1];
    assign p1_deny     = deny_q[0];
    assign p2_deny     = deny_q[1];
    assign bomb_num_p1 = count[0];
    assign bomb_num_p2 = count[1];
    assign prio        = prio_q;

endmodule

// File: tb/tb_bomb_put_arbiter.sv
// Bench for bomb_put_arbiter: directed scenarios plus a randomized run
// compared against a grant-time based reference model.
module tb_bomb_put_arbiter;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         enable = 1'b1;
    logic         p1_req = 1'b0;
    logic         p2_req = 1'b0;
    logic [7:0]   p1_cor = 8'h00;
    logic [7:0]   p2_cor = 8'h00;
    logic [2:0]   p1_bomb_cap = 3'd2;
    logic [2:0]   p2_bomb_cap = 3'd2;
    logic [255:0] bomb_un_grid = '0;
    logic [255:0] explode = '0;
    logic         p1_put, p2_put, p1_deny, p2_deny, prio;
    logic [2:0]   bomb_num_p1, bomb_num_p2;

    int checks = 0;
    int errors = 0;

    // Reference model: grant times per player, button history, request phase.
    int cyc = 0;
    int grants0[$];
    int grants1[$];
    bit hist_m[2];
    bit act_m[2];
    bit pend_m[2];
    bit m_put[2];
    bit m_deny[2];
    bit m_prio;
    int m_num[2];

    bomb_put_arbiter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .p1_req       (p1_req),
        .p2_req       (p2_req),
        .p1_cor       (p1_cor),
        .p2_cor       (p2_cor),
        .p1_bomb_cap  (p1_bomb_cap),
        .p2_bomb_cap  (p2_bomb_cap),
        .bomb_un_grid (bomb_un_grid),
        .explode      (explode),
        .p1_put       (p1_put),
        .p2_put       (p2_put),
        .p1_deny      (p1_deny),
        .p2_deny      (p2_deny),
        .bomb_num_p1  (bomb_num_p1),
        .bomb_num_p2  (bomb_num_p2),
        .prio         (prio)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic bit req_of(int p);
        return (p == 0) ? p1_req : p2_req;
    endfunction

    function automatic int cor_of(int p);
        return (p == 0) ? int'(p1_cor) : int'(p2_cor);
    endfunction

    function automatic int cap_of(int p);
        int c;
        c = (p == 0) ? int'(p1_bomb_cap) : int'(p2_bomb_cap);
        if (c == 0) c = 1;
        if (c > 4) c = 4;
        return c;
    endfunction

    function automatic int live_of(int p);
        return (p == 0) ? grants0.size() : grants1.size();
    endfunction

    task automatic clear_model();
        grants0.delete();
        grants1.delete();
        for (int p = 0; p < 2; p++) begin
            hist_m[p] = 0; act_m[p] = 0; pend_m[p] = 0;
            m_put[p] = 0; m_deny[p] = 0; m_num[p] = 0;
        end
        m_prio = 0;
    endtask

    // Advance one clock: update the model from inputs seen at the edge, then park on the falling edge.
    task automatic tick();
        bit el[2];
        int w;
        @(posedge clk);
        if (reset_n) begin
            cyc++;
            for (int p = 0; p < 2; p++) begin
                el[p] = pend_m[p] && enable && (live_of(p) < cap_of(p))
                        && !bomb_un_grid[cor_of(p)] && !explode[cor_of(p)];
                m_put[p] = 0;
                m_deny[p] = 0;
            end
            if (pend_m[0] && pend_m[1] && el[0] && el[1] && cor_of(0) == cor_of(1)) begin
                w = m_prio ? 1 : 0;
                m_put[w] = 1;
                m_deny[1 - w] = 1;
                m_prio = !m_prio;
            end else begin
                for (int p = 0; p < 2; p++) begin
                    if (pend_m[p]) begin
                        m_put[p] = el[p];
                        m_deny[p] = !el[p];
                    end
                end
            end
            if (m_put[0]) grants0.push_back(cyc);
            if (m_put[1]) grants1.push_back(cyc);
            for (int p = 0; p < 2; p++) begin
                if (pend_m[p]) pend_m[p] = 0;
                else if (act_m[p]) begin
                    if (!req_of(p)) act_m[p] = 0;
                end else if (req_of(p) && !hist_m[p]) begin
                    pend_m[p] = 1;
                    act_m[p] = 1;
                end
                hist_m[p] = req_of(p);
            end
            while (grants0.size() > 0 && cyc - grants0[0] >= 61) void'(grants0.pop_front());
            while (grants1.size() > 0 && cyc - grants1[0] >= 61) void'(grants1.pop_front());
            m_num[0] = grants0.size();
            m_num[1] = grants1.size();
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_model();
        repeat (3) tick();
        if (p1_put !== 1'b0) begin errors++; $display("[TB] FAIL reset_p1_put: got %b want 0", p1_put); end checks++;
        if (p2_put !== 1'b0) begin errors++; $display("[TB] FAIL reset_p2_put: got %b want 0", p2_put); end checks++;
        if (p1_deny !== 1'b0 || p2_deny !== 1'b0) begin errors++; $display("[TB] FAIL reset_deny: got %b%b want 00", p2_deny, p1_deny); end checks++;
        if (bomb_num_p1 !== 3'd0 || bomb_num_p2 !== 3'd0) begin errors++; $display("[TB] FAIL reset_num: got %0d/%0d want 0/0", bomb_num_p1, bomb_num_p2); end checks++;
        if (prio !== 1'b0) begin errors++; $display("[TB] FAIL reset_prio: got %b want 0", prio); end checks++;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single_put();
        p1_cor = 8'h22;
        p1_bomb_cap = 3'd2;
        p1_req = 1'b1;
        tick();
        if (p1_put !== 1'b0) begin errors++; $display("[TB] FAIL single_early: p1_put got %b want 0", p1_put); end checks++;
        tick();
        if (p1_put !== 1'b1) begin errors++; $display("[TB] FAIL single_put: p1_put got %b want 1", p1_put); end checks++;
        if (bomb_num_p1 !== 3'd1) begin errors++; $display("[TB] FAIL single_num: got %0d want 1", bomb_num_p1); end checks++;
        tick();
        if (p1_put !== 1'b0) begin errors++; $display("[TB] FAIL single_width: p1_put got %b want 0", p1_put); end checks++;
        p1_req = 1'b0;
        repeat (59) tick();
        if (bomb_num_p1 !== 3'd1) begin errors++; $display("[TB] FAIL single_life_end: got %0d want 1", bomb_num_p1); end checks++;
        tick();
        if (bomb_num_p1 !== 3'd0) begin errors++; $display("[TB] FAIL single_expired: got %0d want 0", bomb_num_p1); end checks++;
    endtask

    task automatic test_hold();
        int nput = 0;
        int nden = 0;
        p1_req = 1'b1;
        repeat (200) begin
            tick();
            if (p1_put) nput++;
            if (p1_deny) nden++;
        end
        if (nput != 1) begin errors++; $display("[TB] FAIL hold_puts: got %0d want 1", nput); end checks++;
        if (nden != 0) begin errors++; $display("[TB] FAIL hold_denies: got %0d want 0", nden); end checks++;
        p1_req = 1'b0;
        repeat (2) tick();
        p1_req = 1'b1;
        repeat (3) tick();
        p1_req = 1'b0;
        repeat (2) tick();
        p1_req = 1'b1;
        repeat (2) tick();
        if (p1_put !== 1'b1) begin errors++; $display("[TB] FAIL hold_second_put: got %b want 1", p1_put); end checks++;
        if (bomb_num_p1 !== 3'd2) begin errors++; $display("[TB] FAIL hold_two_live: got %0d want 2", bomb_num_p1); end checks++;
        p1_req = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_cap();
        repeat (70) tick();
        p1_bomb_cap = 3'd1;
        p1_req = 1'b1;
        repeat (2) tick();
        if (p1_put !== 1'b1) begin errors++; $display("[TB] FAIL cap_first_put: got %b want 1", p1_put); end checks++;
        p1_req = 1'b0;
        repeat (8) tick();
        p1_req = 1'b1;
        repeat (2) tick();
        if (p1_deny !== 1'b1 || p1_put !== 1'b0) begin errors++; $display("[TB] FAIL cap_full_deny: put/deny got %b/%b want 0/1", p1_put, p1_deny); end checks++;
        p1_req = 1'b0;
        repeat (49) tick();
        p1_req = 1'b1;
        repeat (2) tick();
        if (p1_deny !== 1'b1) begin errors++; $display("[TB] FAIL cap_free_same_cycle: p1_deny got %b want 1", p1_deny); end checks++;
        p1_req = 1'b0;
        repeat (2) tick();
        p1_req = 1'b1;
        repeat (2) tick();
        if (p1_put !== 1'b1) begin errors++; $display("[TB] FAIL cap_after_free: p1_put got %b want 1", p1_put); end checks++;
        p1_req = 1'b0;
        p1_bomb_cap = 3'd2;
        repeat (2) tick();
    endtask

    task automatic test_conflict();
        repeat (70) tick();
        p1_cor = 8'h55; p2_cor = 8'h55;
        p1_req = 1'b1; p2_req = 1'b1;
        repeat (2) tick();
        if (p1_put !== 1'b1 || p2_deny !== 1'b1 || p2_put !== 1'b0) begin errors++; $display("[TB] FAIL conflict1: p1_put/p2_put/p2_deny got %b%b%b want 101", p1_put, p2_put, p2_deny); end checks++;
        if (prio !== 1'b1) begin errors++; $display("[TB] FAIL conflict1_prio: got %b want 1", prio); end checks++;
        p1_req = 1'b0; p2_req = 1'b0;
        repeat (2) tick();
        p1_cor = 8'h56; p2_cor = 8'h56;
        p1_req = 1'b1; p2_req = 1'b1;
        repeat (2) tick();
        if (p2_put !== 1'b1 || p1_deny !== 1'b1 || p1_put !== 1'b0) begin errors++; $display("[TB] FAIL conflict2: p2_put/p1_put/p1_deny got %b%b%b want 101", p2_put, p1_put, p1_deny); end checks++;
        if (prio !== 1'b0) begin errors++; $display("[TB] FAIL conflict2_prio: got %b want 0", prio); end checks++;
        p1_req = 1'b0; p2_req = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_diff_tiles_blocked();
        repeat (70) tick();
        p1_cor = 8'h10; p2_cor = 8'h11;
        p1_req = 1'b1; p2_req = 1'b1;
        repeat (2) tick();
        if (p1_put !== 1'b1 || p2_put !== 1'b1) begin errors++; $display("[TB] FAIL diff_both_put: got %b%b want 11", p1_put, p2_put); end checks++;
        if (prio !== 1'b0) begin errors++; $display("[TB] FAIL diff_prio: got %b want 0", prio); end checks++;
        p1_req = 1'b0; p2_req = 1'b0;
        repeat (2) tick();
        bomb_un_grid[8'h40] = 1'b1;
        explode[8'h41] = 1'b1;
        p1_cor = 8'h40; p2_cor = 8'h41;
        p1_req = 1'b1; p2_req = 1'b1;
        repeat (2) tick();
        if (p1_deny !== 1'b1 || p1_put !== 1'b0) begin errors++; $display("[TB] FAIL blocked_bomb: put/deny got %b/%b want 0/1", p1_put, p1_deny); end checks++;
        if (p2_deny !== 1'b1 || p2_put !== 1'b0) begin errors++; $display("[TB] FAIL blocked_explode: put/deny got %b/%b want 0/1", p2_put, p2_deny); end checks++;
        p1_req = 1'b0; p2_req = 1'b0;
        repeat (2) tick();
        bomb_un_grid = '0;
        explode = '0;
    endtask

    task automatic test_enable_and_reset();
        repeat (70) tick();
        enable = 1'b0;
        p1_cor = 8'h20;
        p1_req = 1'b1;
        repeat (2) tick();
        if (p1_deny !== 1'b1 || p1_put !== 1'b0) begin errors++; $display("[TB] FAIL disabled_deny: put/deny got %b/%b want 0/1", p1_put, p1_deny); end checks++;
        if (bomb_num_p1 !== 3'd0) begin errors++; $display("[TB] FAIL disabled_num: got %0d want 0", bomb_num_p1); end checks++;
        p1_req = 1'b0;
        enable = 1'b1;
        repeat (2) tick();
        p1_cor = 8'h60; p2_cor = 8'h60;
        p1_req = 1'b1; p2_req = 1'b1;
        repeat (2) tick();
        if (prio !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_prio: got %b want 1", prio); end checks++;
        p1_req = 1'b0; p2_req = 1'b0;
        repeat (2) tick();
        p1_cor = 8'h61;
        p1_req = 1'b1;
        tick();
        reset_n = 1'b0;
        clear_model();
        #1;
        if (p1_put !== 1'b0 || p1_deny !== 1'b0) begin errors++; $display("[TB] FAIL midreset_pulse: put/deny got %b/%b want 0/0", p1_put, p1_deny); end checks++;
        if (bomb_num_p1 !== 3'd0) begin errors++; $display("[TB] FAIL midreset_num: got %0d want 0", bomb_num_p1); end checks++;
        if (prio !== 1'b0) begin errors++; $display("[TB] FAIL midreset_prio: got %b want 0", prio); end checks++;
        p1_req = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (3) begin
            tick();
            if (p1_put !== 1'b0 || p1_deny !== 1'b0) begin errors++; $display("[TB] FAIL postreset_pulse: put/deny got %b/%b want 0/0", p1_put, p1_deny); end checks++;
        end
    endtask

    task automatic test_random();
        int dur0 = 0;
        int dur1 = 0;
        int idx;
        for (int n = 0; n < 2500; n++) begin
            if (dur0 == 0) begin
                p1_req = !p1_req;
                dur0 = p1_req ? int'($urandom_range(1, 6)) : int'($urandom_range(1, 4));
                if (!p1_req) p1_cor = 8'h70 + 8'($urandom_range(0, 3));
            end else dur0--;
            if (dur1 == 0) begin
                p2_req = !p2_req;
                dur1 = p2_req ? int'($urandom_range(1, 6)) : int'($urandom_range(1, 4));
                if (!p2_req) p2_cor = 8'h70 + 8'($urandom_range(0, 3));
            end else dur1--;
            if (n % 60 == 0) begin
                p1_bomb_cap = 3'($urandom_range(0, 7));
                p2_bomb_cap = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 7) == 0) begin
                idx = 'h70 + int'($urandom_range(0, 3));
                if ($urandom_range(0, 1) == 0) bomb_un_grid[idx] = !bomb_un_grid[idx];
                else explode[idx] = !explode[idx];
            end
            enable = ($urandom_range(0, 15) != 0);
            tick();
            if (p1_put !== m_put[0] || p1_deny !== m_deny[0]) begin errors++; $display("[TB] FAIL rand_p1_pulse @%0d: put/deny got %b/%b want %b/%b", cyc, p1_put, p1_deny, m_put[0], m_deny[0]); end checks++;
            if (p2_put !== m_put[1] || p2_deny !== m_deny[1]) begin errors++; $display("[TB] FAIL rand_p2_pulse @%0d: put/deny got %b/%b want %b/%b", cyc, p2_put, p2_deny, m_put[1], m_deny[1]); end checks++;
            if (bomb_num_p1 !== 3'(m_num[0]) || bomb_num_p2 !== 3'(m_num[1])) begin errors++; $display("[TB] FAIL rand_num @%0d: got %0d/%0d want %0d/%0d", cyc, bomb_num_p1, bomb_num_p2, m_num[0], m_num[1]); end checks++;
            if (prio !== m_prio) begin errors++; $display("[TB] FAIL rand_prio @%0d: got %b want %b", cyc, prio, m_prio); end checks++;
        end
        p1_req = 1'b0; p2_req = 1'b0; enable = 1'b1;
        tick();
    endtask

    // Run every scenario in order, then report.
    initial begin
        clear_model();
        @(negedge clk);
        test_reset();
        test_single_put();
        test_hold();
        test_cap();
        test_conflict();
        test_diff_tiles_blocked();
        test_enable_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
